// File: rtl/capture_ctrl.sv
// ----------------------------------------------------------------------------
// capture_ctrl
//
// Triggered capture controller for a downsampled 8-bit ADC stream. Once
// armed it watches the sample stream for a level crossing. It then records
// pDepth samples into an internal buffer, starting with the triggering
// sample. Finally it streams the buffer out one byte at a time through a
// UART-style DV / done handshake.
//
// Parameters
//   pDepth       samples per capture record (power of two, 16..4096)
//   pAddrW       buffer address width, log2(pDepth)
//
// Ports
//   iClk         system clock, all logic on the rising edge
//   iRst_n       asynchronous active-low reset, released synchronously
//   iData        unsigned 8-bit sample
//   iData_Valid  one-cycle strobe qualifying iData
//   iArm         one-cycle request to arm the trigger (honoured in IDLE only)
//   iAbort       one-cycle request to drop everything and return to IDLE
//   iTrigLevel   unsigned trigger threshold, used live on every compare
//   iTrigRising  1 = rising-edge trigger, 0 = falling-edge trigger
//   iTx_Done     one-cycle strobe: the transmitter finished the current byte
//   oTx_DV       one-cycle strobe requesting transmission of oTx_Byte
//   oTx_Byte     byte to transmit, held from oTx_DV until iTx_Done
//   oState       IDLE=0, ARMED=1, CAPTURE=2, READ=3, SEND=4
//   oDone        one-cycle strobe after the last byte of a record is acked
// ----------------------------------------------------------------------------
module capture_ctrl #(
  parameter int pDepth = 256,
  parameter int pAddrW = 8
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iData,
  input  logic       iData_Valid,
  input  logic       iArm,
  input  logic       iAbort,
  input  logic [7:0] iTrigLevel,
  input  logic       iTrigRising,
  input  logic       iTx_Done,
  output logic       oTx_DV,
  output logic [7:0] oTx_Byte,
  output logic [2:0] oState,
  output logic       oDone
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    READ    = 3'd3,
    SEND    = 3'd4
  } state_t;

  localparam logic [pAddrW-1:0] LAST_ADDR = pAddrW'(pDepth - 1);

  state_t            state;
  state_t            next_state;
  logic              run_en;

  logic [7:0]        buffer_mem [pDepth];
  logic [pAddrW-1:0] wr_ptr;
  logic [pAddrW-1:0] rd_ptr;
  logic [7:0]        rd_data;

  logic [7:0]        prev_sample;
  logic              prev_valid;

  logic              trig_hit;
  logic              wr_en;
  logic [pAddrW-1:0] wr_addr;
  logic              rd_en;
  logic              dv_next;
  logic              done_next;
  logic              tx_dv;
  logic              done;

  // Reset release gate: the first edge after iRst_n rises only sets this
  // flag, so the FSM can make its first move on the second edge.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      run_en <= 1'b0;
    end else begin
      run_en <= 1'b1;
    end
  end

  // Trigger compare. It uses the live threshold and polarity every cycle
  // and needs a previous sample from the current arming.
  always_comb begin
    trig_hit = 1'b0;
    if (prev_valid && iData_Valid) begin
      if (iTrigRising) begin
        trig_hit = (prev_sample < iTrigLevel) && (iData >= iTrigLevel);
      end else begin
        trig_hit = (prev_sample > iTrigLevel) && (iData <= iTrigLevel);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic. Abort overrides every other request.
  always_comb begin
    next_state = state;
    if (run_en) begin
      if (iAbort) begin
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (iArm) begin
              next_state = ARMED;
            end
          end
          ARMED: begin
            if (trig_hit) begin
              next_state = CAPTURE;
            end
          end
          CAPTURE: begin
            if (iData_Valid && (wr_ptr == LAST_ADDR)) begin
              next_state = READ;
            end
          end
          READ: begin
            next_state = SEND;
          end
          SEND: begin
            if (iTx_Done) begin
              next_state = (rd_ptr == LAST_ADDR) ? IDLE : READ;
            end
          end
          default: begin
            next_state = IDLE;
          end
        endcase
      end
    end
  end

  // FSM outputs: buffer write/read enables and the next values of the
  // registered DV and done strobes.
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = wr_ptr;
    rd_en     = 1'b0;
    dv_next   = 1'b0;
    done_next = 1'b0;
    if (run_en && !iAbort) begin
      case (state)
        ARMED: begin
          // The triggering sample always lands at address 0.
          if (trig_hit) begin
            wr_en   = 1'b1;
            wr_addr = '0;
          end
        end
        CAPTURE: begin
          wr_en = iData_Valid;
        end
        READ: begin
          rd_en   = 1'b1;
          dv_next = 1'b1;
        end
        SEND: begin
          done_next = iTx_Done && (rd_ptr == LAST_ADDR);
        end
        default: begin
          wr_en = 1'b0;
        end
      endcase
    end
  end

  // Pointers, previous-sample tracking and the registered strobes.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      prev_sample <= 8'h00;
      prev_valid  <= 1'b0;
      tx_dv       <= 1'b0;
      done        <= 1'b0;
    end else begin
      tx_dv <= dv_next;
      done  <= done_next;
      if (run_en) begin
        if (iAbort) begin
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          prev_valid <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              prev_valid <= 1'b0;
            end
            ARMED: begin
              if (iData_Valid) begin
                prev_sample <= iData;
                prev_valid  <= 1'b1;
              end
              if (trig_hit) begin
                wr_ptr <= pAddrW'(1);
              end
            end
            CAPTURE: begin
              // The last write wraps the pointer back to 0 by overflow.
              if (iData_Valid) begin
                wr_ptr <= wr_ptr + pAddrW'(1);
              end
            end
            SEND: begin
              // After the final byte this also wraps to 0 for the next record.
              if (iTx_Done) begin
                rd_ptr <= rd_ptr + pAddrW'(1);
              end
            end
            default: begin
              prev_valid <= prev_valid;
            end
          endcase
        end
      end
    end
  end

  // Sample buffer, synchronous write.
  always_ff @(posedge iClk) begin
    if (wr_en) begin
      buffer_mem[wr_addr] <= iData;
    end
  end

  // Registered buffer read. The byte stays put until the next READ, so it
  // is stable across the whole SEND wait.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= buffer_mem[rd_ptr];
    end
  end

  assign oTx_DV   = tx_dv;
  assign oTx_Byte = rd_data;
  assign oState   = state;
  assign oDone    = done;

endmodule

// File: tb/tb_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_capture_ctrl
//
// Self-checking bench for capture_ctrl (default 256-sample record).
// A vector table exercises the arm / trigger / abort control paths one
// cycle at a time. Full records are then driven with random sample streams.
// A reference model picks the trigger point straight from the crossing
// rules, and the transmitted bytes are compared against the samples that
// follow it. An automatic responder answers each oTx_DV with iTx_Done.
// ----------------------------------------------------------------------------
module tb_capture_ctrl;

  localparam int Depth = 256;
  localparam int AddrW = 8;

  logic       iClk        = 1'b0;
  logic       iRst_n      = 1'b1;
  logic [7:0] iData       = 8'h00;
  logic       iData_Valid = 1'b0;
  logic       iArm        = 1'b0;
  logic       iAbort      = 1'b0;
  logic [7:0] iTrigLevel  = 8'h80;
  logic       iTrigRising = 1'b1;
  logic       iTx_Done;
  logic       oTx_DV;
  logic [7:0] oTx_Byte;
  logic [2:0] oState;
  logic       oDone;

  logic manual_done = 1'b0;
  logic resp_done   = 1'b0;
  assign iTx_Done = manual_done | resp_done;

  capture_ctrl #(.pDepth(Depth), .pAddrW(AddrW)) dut (
    .iClk        (iClk),
    .iRst_n      (iRst_n),
    .iData       (iData),
    .iData_Valid (iData_Valid),
    .iArm        (iArm),
    .iAbort      (iAbort),
    .iTrigLevel  (iTrigLevel),
    .iTrigRising (iTrigRising),
    .iTx_Done    (iTx_Done),
    .oTx_DV      (oTx_DV),
    .oTx_Byte    (oTx_Byte),
    .oState      (oState),
    .oDone       (oDone)
  );

  always #5 iClk = ~iClk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge iClk) cyc++;

  // Readout monitor and transmitter model. It collects every DV byte and
  // answers it with iTx_Done resp_delay cycles later. The DV numbered
  // hold_at is left unanswered so an abort can land in SEND.
  int         dv_count;
  int         done_count;
  int         ack_count;
  int         overlap_count;
  int         first_dv_cyc;
  int         pending;
  int         resp_delay = 10;
  int         hold_at    = 0;
  logic [7:0] rx_q[$];

  always @(negedge iClk) begin
    resp_done = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) begin
        resp_done = 1'b1;
        ack_count++;
      end
    end
    if (oTx_DV) begin
      if (pending > 0) overlap_count++;
      if (dv_count == 0) first_dv_cyc = cyc;
      dv_count++;
      rx_q.push_back(oTx_Byte);
      if (dv_count != hold_at) pending = resp_delay;
    end
    if (oDone) done_count++;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clear_monitor();
    dv_count      = 0;
    done_count    = 0;
    ack_count     = 0;
    overlap_count = 0;
    first_dv_cyc  = -1;
    pending       = 0;
    rx_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       arm;
    logic       abort;
    logic       valid;
    logic [7:0] data;
    logic [7:0] level;
    logic       rising;
    logic       tx_done;
    logic [2:0] exp_state;
    logic       exp_dv;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic arm, input logic abort, input logic valid,
                              input logic [7:0] data, input logic [7:0] level,
                              input logic rising, input logic tx_done,
                              input logic [2:0] st);
    vec_t v;
    v.arm = arm; v.abort = abort; v.valid = valid; v.data = data;
    v.level = level; v.rising = rising; v.tx_done = tx_done;
    v.exp_state = st; v.exp_dv = 1'b0; v.exp_done = 1'b0;
    return v;
  endfunction

  // Drives one table row for exactly one clock, starting just after an edge.
  task automatic applyStimulus(input vec_t v);
    iArm        = v.arm;
    iAbort      = v.abort;
    iData_Valid = v.valid;
    iData       = v.data;
    iTrigLevel  = v.level;
    iTrigRising = v.rising;
    manual_done = v.tx_done;
    @(posedge iClk);
    #1;
    iArm = 1'b0; iAbort = 1'b0; iData_Valid = 1'b0; manual_done = 1'b0;
  endtask

  // ---------------- record-level reference model ----------------
  logic [7:0] stream_q[$];
  logic [7:0] exp_q[$];
  int         trig_idx;
  int         last_wr_cyc;

  function automatic bit is_trigger(input logic [7:0] prev, input logic [7:0] cur,
                                    input logic [7:0] level, input logic rising);
    if (rising) return (prev < level) && (cur >= level);
    return (prev > level) && (cur <= level);
  endfunction

  task automatic feed_sample(input logic [7:0] d, input int gap);
    repeat (gap) begin
      @(posedge iClk);
      #1;
    end
    iData       = d;
    iData_Valid = 1'b1;
    @(posedge iClk);
    #1;
    iData_Valid = 1'b0;
  endtask

  // Builds a stream, arms the DUT and feeds it. The model finds the first
  // crossing after the first sample and expects the next Depth samples
  // from there. Extra samples land during readout and must be dropped.
  task automatic start_record(input logic [7:0] level, input logic rising,
                              input bit use_prefix, input int delay, input int extras);
    clear_monitor();
    resp_delay  = delay;
    iTrigLevel  = level;
    iTrigRising = rising;
    stream_q.delete();
    exp_q.delete();
    if (use_prefix) begin
      stream_q.push_back(8'h10);
      stream_q.push_back(8'h70);
      stream_q.push_back(8'h90);
    end
    trig_idx = -1;
    for (int i = 1; i < stream_q.size(); i++) begin
      if (trig_idx < 0 && is_trigger(stream_q[i-1], stream_q[i], level, rising)) trig_idx = i;
    end
    while (trig_idx < 0 && stream_q.size() < 3000) begin
      stream_q.push_back(8'($urandom));
      if (stream_q.size() >= 2 &&
          is_trigger(stream_q[stream_q.size()-2], stream_q[stream_q.size()-1], level, rising))
        trig_idx = stream_q.size() - 1;
    end
    if (trig_idx < 0) begin
      $display("[TB] FAIL stream_gen: got no crossing, expected one");
      $fatal(1, "[TB] stream generation");
    end
    while (stream_q.size() < trig_idx + Depth) stream_q.push_back(8'($urandom));
    for (int i = 0; i < Depth; i++) exp_q.push_back(stream_q[trig_idx + i]);

    iArm = 1'b1;
    @(posedge iClk);
    #1;
    iArm = 1'b0;
    for (int i = 0; i < stream_q.size(); i++) begin
      feed_sample(stream_q[i], $urandom_range(0, 2));
      if (i == trig_idx + Depth - 1) last_wr_cyc = cyc;
    end
    for (int k = 0; k < extras; k++) feed_sample(8'($urandom), $urandom_range(0, 4));
  endtask

  task automatic finish_record(input string tag);
    int budget;
    int timed_out;
    int errs;
    int lat_ok;
    budget    = Depth * (resp_delay + 4) + 2000;
    timed_out = 1;
    for (int c = 0; c < budget; c++) begin
      if (done_count > 0) begin
        timed_out = 0;
        break;
      end
      @(posedge iClk);
      #1;
    end
    repeat (3) @(posedge iClk);
    #1;
    checkOutput({tag, "_timeout"}, timed_out, 0);
    checkOutput({tag, "_dv_count"}, dv_count, Depth);
    checkOutput({tag, "_ack_count"}, ack_count, Depth);
    checkOutput({tag, "_done_count"}, done_count, 1);
    checkOutput({tag, "_dv_while_waiting"}, overlap_count, 0);
    checkOutput({tag, "_state_after"}, int'(oState), 0);
    errs = 0;
    for (int i = 0; i < Depth; i++) begin
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) errs++;
    end
    checkOutput({tag, "_byte_errors"}, errs, 0);
    lat_ok = (first_dv_cyc - last_wr_cyc >= 1) && (first_dv_cyc - last_wr_cyc <= 3);
    checkOutput({tag, "_readout_latency_ok"}, lat_ok, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_monitor();

    // Reset state.
    #1 iRst_n = 1'b0;
    #1;
    checkOutput("reset_state", int'(oState), 0);
    checkOutput("reset_dv", int'(oTx_DV), 0);
    checkOutput("reset_byte", int'(oTx_Byte), 0);
    checkOutput("reset_done", int'(oDone), 0);
    #20 iRst_n = 1'b1;
    repeat (3) @(posedge iClk);
    #1;

    // Control-path table: arm, level crossings, abort priority, ignored strobes.
    //              arm   abort valid data   level  rise  txd   state
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1, 3'd0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h55, 8'h80, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b1, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h30, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA0, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h40, 8'h40, 1'b0, 1'b0, 3'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b1, 3'd2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h10, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h70, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h90, 8'h80, 1'b1, 1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h95, 8'h80, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h90, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h50, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h60, 8'h55, 1'b1, 1'b0, 3'd2));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h40, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h40, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h41, 8'h40, 1'b0, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h40, 8'h40, 1'b0, 1'b0, 3'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h10, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h90, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h10, 8'h80, 1'b1, 1'b0, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h90, 8'h80, 1'b1, 1'b0, 3'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1, 3'd1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_state", i), int'(oState), int'(vecs[i].exp_state));
      checkOutput($sformatf("vec%0d_dv", i), int'(oTx_DV), int'(vecs[i].exp_dv));
      checkOutput($sformatf("vec%0d_done", i), int'(oDone), int'(vecs[i].exp_done));
    end
    repeat (2) @(posedge iClk);
    #1;

    // Known rising record: 0x10, 0x70, 0x90 ... with a 10-cycle transmitter.
    start_record(8'h80, 1'b1, 1'b1, 10, 20);
    finish_record("rise_record");
    checkOutput("rise_record_first_byte", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'h90);

    // Abort while waiting on the 17th byte.
    hold_at = 17;
    start_record(8'h60, 1'b0, 1'b0, 3, 0);
    begin
      int waited = 0;
      while (dv_count < 17 && waited < 5000) begin
        @(posedge iClk);
        #1;
        waited++;
      end
      checkOutput("abort_reach_byte17", int'(dv_count >= 17), 1);
    end
    repeat (3) @(posedge iClk);
    #1;
    iAbort = 1'b1;
    @(posedge iClk);
    #1;
    iAbort = 1'b0;
    checkOutput("abort_state_next", int'(oState), 0);
    repeat (60) @(posedge iClk);
    #1;
    checkOutput("abort_dv_count", dv_count, 17);
    checkOutput("abort_no_done", done_count, 0);
    hold_at = 0;
    start_record(8'($urandom_range(32, 224)), 1'($urandom), 1'b0, 4, 15);
    finish_record("after_abort");

    // Reset in the middle of a capture.
    clear_monitor();
    iTrigLevel  = 8'h80;
    iTrigRising = 1'b1;
    iArm = 1'b1;
    @(posedge iClk);
    #1;
    iArm = 1'b0;
    feed_sample(8'h10, 0);
    feed_sample(8'h90, 1);
    for (int k = 0; k < 50; k++) feed_sample(8'($urandom), $urandom_range(0, 2));
    checkOutput("pre_reset_capturing", int'(oState), 2);
    #1 iRst_n = 1'b0;
    #1;
    checkOutput("midrst_state", int'(oState), 0);
    checkOutput("midrst_dv", int'(oTx_DV), 0);
    checkOutput("midrst_byte", int'(oTx_Byte), 0);
    checkOutput("midrst_done", int'(oDone), 0);
    repeat (3) @(posedge iClk);
    #2 iRst_n = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    checkOutput("midrst_no_dv", dv_count, 0);
    start_record(8'h80, 1'b1, 1'b1, 2, 10);
    finish_record("after_reset");

    // Random records against the model.
    for (int r = 0; r < 3; r++) begin
      start_record(8'($urandom_range(32, 224)), 1'($urandom), 1'b0,
                   $urandom_range(1, 12), $urandom_range(0, 30));
      finish_record($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter pDepth, default 256, number of samples per capture record (power of two, 16..4096).
REQ-002 SHALL have parameter pAddrW, default 8, buffer address width, equal to log2(pDepth).
REQ-003 SHALL have port iClk  input  1  system clock (100 MHz), all logic on rising edge.
REQ-004 SHALL have port iRst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port iData  input  8  unsigned downsampled ADC sample.
REQ-006 SHALL have port iData_Valid  input  1  one-cycle strobe qualifying iData.
REQ-007 SHALL have port iArm  input  1  one-cycle request to arm the trigger.
REQ-008 SHALL have port iAbort  input  1  one-cycle request to return to IDLE.
REQ-009 SHALL have port iTrigLevel  input  8  unsigned trigger threshold.
REQ-010 SHALL have port iTrigRising  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-011 SHALL have port iTx_Done  input  1  one-cycle strobe from the UART transmitter, byte finished.
REQ-012 SHALL have port oTx_DV  output  1  one-cycle strobe requesting transmission of oTx_Byte.
REQ-013 SHALL have port oTx_Byte  output  8  byte to transmit, stable from oTx_DV until iTx_Done.
REQ-014 SHALL have port oState  output  3  current state encoding: IDLE=0, ARMED=1, CAPTURE=2, READ=3, SEND=4.
REQ-015 SHALL have port oDone  output  1  one-cycle strobe after the last byte of a record is acknowledged.

Function
REQ-016 SHALL contain an internal pDepth x 8 buffer with synchronous write and one-cycle registered read.
REQ-017 IDLE: iArm -> ARMED next cycle; clear previous-sample-valid flag; iData_Valid ignored.
REQ-018 ARMED: each iData_Valid updates the previous-sample register; the first valid sample after arming SHALL NOT trigger.
REQ-019 Rising trigger: prev < iTrigLevel and current >= iTrigLevel.
REQ-020 Falling trigger: prev > iTrigLevel and current <= iTrigLevel.
REQ-021 iTrigLevel and iTrigRising SHALL be sampled on every compare, with no latching.
REQ-022 On trigger: the triggering sample SHALL be written at address 0, write pointer set to 1, state -> CAPTURE.
REQ-023 CAPTURE: each iData_Valid writes at the pointer and increments it; the write at address pDepth-1 -> READ, pointer wraps to 0.
REQ-024 READ: issue a buffer read at the read pointer; the registered data loads oTx_Byte; oTx_DV pulses high for exactly 1 cycle; state -> SEND.
REQ-025 Readout latency: the first oTx_DV SHALL occur no later than 3 cycles after the final capture write.
REQ-026 SEND: wait for iTx_Done; on iTx_Done, if the read pointer = pDepth-1, pulse oDone and -> IDLE; else increment the pointer and -> READ.
REQ-027 Exactly pDepth oTx_DV pulses per record, in address order 0..pDepth-1, with no DV while waiting for iTx_Done.
REQ-028 iTx_Done outside SEND SHALL be ignored.
REQ-029 iArm outside IDLE SHALL be ignored (no re-arm, no restart).
REQ-030 iAbort in any state -> IDLE next cycle, pointers cleared, no further oTx_DV; iAbort wins over simultaneous iArm, trigger or iTx_Done.
REQ-031 iAbort in SEND SHALL NOT produce oDone.
REQ-032 iArm and iAbort together in IDLE -> remain IDLE.
REQ-033 iData_Valid during READ/SEND SHALL be dropped, leaving buffer contents unchanged.
REQ-034 Pointers SHALL be pAddrW bits wide, with wrap by natural overflow.

Reset
REQ-035 iRst_n low SHALL asynchronously force: state IDLE, oState=0, oTx_DV=0, oTx_Byte=0, oDone=0, pointers=0, previous-sample-valid flag=0.
REQ-036 Reset release SHALL be synchronous to iClk; the first transition is possible on the second rising edge after deassertion.
REQ-037 Reset mid-capture or mid-readout SHALL discard the record, with no oTx_DV after reset assertion; buffer contents are don't-care.

Verification
REQ-038 Arm, rising, level 0x80, samples 0x10,0x70,0x90,... -> trigger on 0x90; the first transmitted byte is 0x90, followed by the next pDepth-1 samples.
REQ-039 Falling, level 0x40, samples 0xA0,0x40 -> trigger on 0x40; first sample after arm equal to 0x30 alone -> no trigger.
REQ-040 Full record, iTx_Done returned 10 cycles after each DV -> 256 DV pulses, 256 iTx_Done strobes, one oDone, oState=0 afterwards.
REQ-041 iAbort asserted in SEND at byte 17 -> oState=0 next cycle, no further DV, no oDone; a subsequent iArm captures normally.
REQ-042 iArm during CAPTURE and spurious iTx_Done in ARMED -> no state change, no DV.
REQ-043 iRst_n pulsed low mid-CAPTURE -> all outputs 0 immediately; after release, iArm plus trigger produces a correct full record.
